// File: rtl/uart_pkg.sv
// Shared state encoding and constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path; no bypass, level derived from
// extended read/write pointers.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LVL_W-1:0] r_wptr;
    logic [LVL_W-1:0] r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so their difference is the occupancy.
    assign o_level   = r_wptr - r_rptr;
    assign o_full    = (o_level == LVL_W'(DEPTH));
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + LVL_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: FIFO, per-frame latched prescaler, shifter and FSM.
// Optional parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [DIV_W-1:0] prd,
    input  logic             en,
    input  logic             parity_odd,
    input  logic [7:0]       wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [LVL_W-1:0] level
);

    import uart_pkg::*;

    uart_state_e      r_state;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_prd;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_fifo_data;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;

`ifdef UART_TX_PARITY_EN
    logic             r_par;
`else
    logic             w_unused_parity;
    assign w_unused_parity = parity_odd;
`endif

    assign wready    = ~w_full;
    assign w_push    = wvalid & ~w_full;
    assign w_bit_end = (r_cnt == '0);
    // A new frame may start from idle or right at the end of a stop bit.
    assign w_pop     = en & ~w_empty &
                       ((r_state == StIdle) | ((r_state == StStop) & w_bit_end));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8),
        .LVL_W (LVL_W)
    ) u_fifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (w_push),
        .i_data  (wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= StIdle;
            r_tx    <= UART_IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_prd   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_pop) begin
                r_state <= StStart;
                r_tx    <= 1'b0;
                r_busy  <= 1'b1;
                r_shift <= w_fifo_data;
                r_cnt   <= prd;
                r_prd   <= prd;
                r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                r_par   <= (^w_fifo_data) ^ parity_odd;
`endif
            end else if (r_state != StIdle) begin
                if (!w_bit_end) begin
                    r_cnt <= r_cnt - DIV_W'(1);
                    // Registered done must land on the final stop cycle.
                    if ((r_state == StStop) && (r_cnt == DIV_W'(1))) begin
                        r_done <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_prd;
                    case (r_state)
                        StStart: begin
                            r_state <= StData;
                            r_tx    <= r_shift[0];
                        end
                        StData: begin
                            if (r_bit == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                                r_state <= StParity;
                                r_tx    <= r_par;
`else
                                r_state <= StStop;
                                r_tx    <= UART_IDLE_LEVEL;
                                r_done  <= (r_prd == '0);
`endif
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= r_shift >> 1;
                                r_tx    <= r_shift[1];
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        StParity: begin
                            r_state <= StStop;
                            r_tx    <= UART_IDLE_LEVEL;
                            r_done  <= (r_prd == '0);
                        end
`endif
                        StStop: begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                        default: begin
                            r_state <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms are built from the
// frame format (start, data LSB first, optional parity, stop) per byte.
module tb_uart_tx;

    localparam int DIV_W = 16;
    localparam int LVL_W = 3;

    logic             HCLK;
    logic             HRESET;
    logic [DIV_W-1:0] prd;
    logic             en;
    logic             parity_odd;
    logic [7:0]       wdata;
    logic             wvalid;
    logic             wready;
    logic             tx;
    logic             busy;
    logic             done;
    logic [LVL_W-1:0] level;

    int errors = 0;
    int checks = 0;

    uart_tx #(
        .DIV_W      (DIV_W),
        .FIFO_DEPTH (4),
        .LVL_W      (LVL_W)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .prd        (prd),
        .en         (en),
        .parity_odd (parity_odd),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .level      (level)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_idle(input string name, input logic [LVL_W-1:0] exp_level);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL %s tx: got %b want 1", name, tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b want 0", name, busy);
        end
        checks++;
        if (level !== exp_level) begin
            errors++;
            $display("FAIL %s level: got %0d want %0d", name, level, exp_level);
        end
    endtask

    // Called on the first cycle of the start bit; returns one cycle past the frame.
    task automatic check_frame(input logic [7:0] data, input int p, input logic po,
                               input int next_p, input logic next_po, input int drop_at,
                               input string name);
        logic q[$];
        int   total;
        logic exp_tx;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(data[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back((^data) ^ po);
`endif
        q.push_back(1'b1);
        total = q.size() * (p + 1);
        for (int k = 0; k < total; k++) begin
            exp_tx = q[k / (p + 1)];
            checks++;
            if (tx !== exp_tx) begin
                errors++;
                $display("FAIL %s tx cycle %0d: got %b want %b", name, k, tx, exp_tx);
            end
            checks++;
            if (done !== (k == total - 1)) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, k, done,
                         (k == total - 1));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
            end
            if (k == drop_at) en = 1'b0;
            // Mid-frame changes must not affect the frame in flight.
            if (k == total / 2) begin
                prd        = DIV_W'($urandom);
                parity_odd = 1'($urandom);
            end
            if (k == total - 1) begin
                prd        = DIV_W'(next_p);
                parity_odd = next_po;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; en = 1'b0; wvalid = 1'b0; wdata = 8'h00;
        prd = 16'd15; parity_odd = 1'b0;
        tick();
        tick();
        check_idle("reset_hold", 3'd0);
        HRESET = 1'b0;
        tick();
        check_idle("reset_release", 3'd0);
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL reset wready: got %b want 1", wready);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b want 0", done);
        end
    endtask

    task automatic test_single();
        prd = 16'd15; en = 1'b1; parity_odd = 1'b0;
        wdata = 8'h41; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check_idle("single_push", 3'd1);
        tick();
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL single_pop level: got %0d want 0", level);
        end
        check_frame(8'h41, 15, 1'b0, 15, 1'b0, -1, "single");
        check_idle("single_after", 3'd0);
    endtask

    task automatic test_burst();
        en = 1'b0; prd = 16'd15; parity_odd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'h30 + 8'(i); wvalid = 1'b1;
            checks++;
            if (wready !== (i < 4)) begin
                errors++;
                $display("FAIL burst wready byte %0d: got %b want %b", i, wready, (i < 4));
            end
            tick();
        end
        wvalid = 1'b0;
        check_idle("burst_full", 3'd4);
        en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (level !== LVL_W'(3 - k)) begin
                errors++;
                $display("FAIL burst level frame %0d: got %0d want %0d", k, level, 3 - k);
            end
            check_frame(8'h30 + 8'(k), 15, 1'b0, 15, 1'b0, -1, "burst");
        end
        check_idle("burst_after", 3'd0);
    endtask

    task automatic test_enable_drop();
        logic [7:0] b [3];
        b[0] = 8'hA5; b[1] = 8'h5A; b[2] = 8'h3C;
        en = 1'b0; prd = 16'd7;
        for (int i = 0; i < 3; i++) begin
            wdata = b[i]; wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0;
        en = 1'b1;
        tick();
        // Drop en in data bit 3 (bit slot 4).
        check_frame(b[0], 7, 1'b0, 7, 1'b0, 4 * 8 + 3, "en_drop");
        check_idle("en_drop_after", 3'd2);
        repeat (30) tick();
        check_idle("en_drop_hold", 3'd2);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] v;
        logic       active;
        v = 8'h5A;
        en = 1'b1;
        tick();
        checks++;
        if (tx !== 1'b0 || level !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid start: got tx=%b level=%0d want tx=0 level=1", tx, level);
        end
        repeat (51) tick();
        checks++;
        if (tx !== v[5]) begin
            errors++;
            $display("FAIL rst_mid data5: got %b want %b", tx, v[5]);
        end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check_idle("rst_mid", 3'd0);
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid wready: got %b want 1", wready);
        end
        active = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) active = 1'b1;
        end
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid quiet: got activity=%b want 0", active);
        end
    endtask

    task automatic test_min_prd();
        prd = 16'd0; en = 1'b1; parity_odd = 1'b0;
        wdata = 8'hFF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check_idle("min_push", 3'd1);
        tick();
        check_frame(8'hFF, 0, 1'b0, 0, 1'b0, -1, "min_prd");
        check_idle("min_after", 3'd0);
    endtask

    task automatic test_parity();
        for (int po = 0; po < 2; po++) begin
            prd = 16'd15; en = 1'b1; parity_odd = 1'(po);
            wdata = 8'h41; wvalid = 1'b1;
            tick();
            wvalid = 1'b0;
            tick();
            check_frame(8'h41, 15, 1'(po), 15, 1'(po), -1, "parity");
            check_idle("parity_after", 3'd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int         p;
        int         np;
        logic       po;
        logic       npo;
        for (int r = 0; r < 3; r++) begin
            q.delete();
            en = 1'b0;
            p = int'($urandom_range(0, 3));
            po = 1'($urandom);
            prd = DIV_W'(p); parity_odd = po;
            for (int i = 0; i < 4; i++) begin
                wdata = 8'($urandom); wvalid = 1'b1;
                q.push_back(wdata);
                tick();
            end
            wvalid = 1'b0;
            en = 1'b1;
            tick();
            for (int k = 0; k < 4; k++) begin
                np = int'($urandom_range(0, 3));
                npo = 1'($urandom);
                check_frame(q[k], p, po, np, npo, -1, "b2b_rand");
                p = np;
                po = npo;
            end
            check_idle("b2b_after", 3'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_enable_drop();
        test_reset_mid_frame();
        test_min_prd();
        test_parity();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
